// File: rtl/eth_latency_ping_scheduler.sv
// Latency ping sequencer: paces trigger pulses, owns the ping id and
// times each ping from tx_begin to a matching reply or a timeout.
module eth_latency_ping_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] period,
  input  logic [31:0] timeout,
  output logic        trigger,
  input  logic        tx_begin,
  input  logic        rx_valid,
  input  logic [15:0] rx_ping_id,
  output logic [15:0] ping_id,
  output logic [31:0] latency,
  output logic        latency_valid,
  output logic        lost,
  output logic [31:0] ping_count,
  output logic [31:0] pong_count,
  output logic [31:0] lost_count,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIGGER,
    ST_WAIT_TX,
    ST_WAIT_RX,
    ST_WAIT_PERIOD
  } state_t;

  state_t      state;
  logic [31:0] lat_cnt;
  logic [31:0] period_cnt;
  logic [31:0] lat_inc;
  logic [31:0] period_inc;
  logic        period_done;
  logic        match;
  logic        expired;

  assign lat_inc = (lat_cnt == '1) ? lat_cnt : lat_cnt + 32'd1;
  assign period_inc = (period_cnt == '1) ? period_cnt
                                         : period_cnt + 32'd1;

  // 33-bit compare so period_cnt at saturation cannot wrap
  assign period_done = ({1'b0, period_cnt} + 33'd1) >= {1'b0, period};
  assign match = rx_valid && (rx_ping_id == ping_id);
  assign expired = lat_cnt >= timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      trigger       <= 1'b0;
      latency_valid <= 1'b0;
      lost          <= 1'b0;
      busy          <= 1'b0;
      ping_id       <= '0;
      latency       <= '0;
      ping_count    <= '0;
      pong_count    <= '0;
      lost_count    <= '0;
      lat_cnt       <= '0;
      period_cnt    <= '0;
    end else begin
      trigger       <= 1'b0;
      latency_valid <= 1'b0;
      lost          <= 1'b0;
      if (state != ST_IDLE && state != ST_TRIGGER) begin
        period_cnt <= period_inc;
      end
      unique case (state)
        ST_IDLE: begin
          if (enable) begin
            state   <= ST_TRIGGER;
            trigger <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_TRIGGER: begin
          ping_count <= ping_count + 32'd1;
          period_cnt <= 32'd1;
          state      <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (tx_begin) begin
            lat_cnt <= 32'd1;
            state   <= ST_WAIT_RX;
          end
        end
        ST_WAIT_RX: begin
          lat_cnt <= lat_inc;
          // a reply landing on the timeout cycle still counts
          if (match) begin
            latency       <= lat_cnt;
            latency_valid <= 1'b1;
            pong_count    <= pong_count + 32'd1;
            ping_id       <= ping_id + 16'd1;
            state         <= ST_WAIT_PERIOD;
          end else if (expired) begin
            lost       <= 1'b1;
            lost_count <= lost_count + 32'd1;
            ping_id    <= ping_id + 16'd1;
            state      <= ST_WAIT_PERIOD;
          end
        end
        ST_WAIT_PERIOD: begin
          if (!enable) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (period_done) begin
            state   <= ST_TRIGGER;
            trigger <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_latency_ping_scheduler.sv
// Bench for eth_latency_ping_scheduler: directed and random pings
// checked against a timing model of trigger, latency and timeout.
module tb_eth_latency_ping_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] period;
  logic [31:0] timeout;
  logic        trigger;
  logic        tx_begin;
  logic        rx_valid;
  logic [15:0] rx_ping_id;
  logic [15:0] ping_id;
  logic [31:0] latency;
  logic        latency_valid;
  logic        lost;
  logic [31:0] ping_count;
  logic [31:0] pong_count;
  logic [31:0] lost_count;
  logic        busy;

  int     cmp_n = 0;
  int     err_n = 0;
  longint cyc = 0;
  longint exp_trig = -1;
  longint last_t = 0;
  longint last_r = 0;

  logic [15:0] m_id = 0;
  logic [31:0] m_ping = 0;
  logic [31:0] m_pong = 0;
  logic [31:0] m_lost = 0;
  logic [31:0] m_lat = 0;

  always #5 clk = ~clk;

  eth_latency_ping_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .period        (period),
    .timeout       (timeout),
    .trigger       (trigger),
    .tx_begin      (tx_begin),
    .rx_valid      (rx_valid),
    .rx_ping_id    (rx_ping_id),
    .ping_id       (ping_id),
    .latency       (latency),
    .latency_valid (latency_valid),
    .lost          (lost),
    .ping_count    (ping_count),
    .pong_count    (pong_count),
    .lost_count    (lost_count),
    .busy          (busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_period(input int unsigned p);
    longint e;
    period = p;
    if (enable && exp_trig > cyc) begin
      e = last_t + p;
      if (last_r + 2 > e) e = last_r + 2;
      if (cyc + 1 > e) e = cyc + 1;
      exp_trig = e;
    end
  endtask

  task automatic wait_trigger(output longint t);
    int b = 0;
    while (trigger !== 1'b1 && b < 2000) begin
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_ping_id = m_id;
      step;
      b++;
    end
    rx_valid = 1'b0;
    t = cyc;
    cmp_n++;
    if (b >= 2000) begin
      err_n++;
      $display("FAIL trigger_wait: no trigger after %0d cycles", b);
    end else if (exp_trig >= 0 && cyc != exp_trig) begin
      err_n++;
      $display("FAIL trigger_time: got cycle %0d want %0d",
               cyc, exp_trig);
    end
    m_ping++;
  endtask

  // n: reply offset after tx_begin (0 = none); mn/mid: stray reply
  task automatic run_ping(input int txd, input int n, input int mn,
                          input logic [15:0] mid, input bit late,
                          input bit drop);
    longint t;
    longint b_cyc;
    int     eff;
    int     res;
    bit     hit;
    logic [2:0] want;
    logic [2:0] got;
    wait_trigger(t);
    repeat (txd) step;
    tx_begin = 1'b1;
    b_cyc = cyc;
    step;
    tx_begin = 1'b0;
    eff = (timeout == 0) ? 1 : int'(timeout);
    hit = (n > 0 && n <= eff);
    res = hit ? n : eff;
    if (drop) enable = 1'b0;
    for (int k = 1; k <= res + 1; k++) begin
      want = {1'b0, (k == res + 1) && hit, (k == res + 1) && !hit};
      got = {trigger, latency_valid, lost};
      cmp_n++;
      if (got !== want) begin
        err_n++;
        $display("FAIL pulses@B+%0d: got %b want %b", k, got, want);
      end
      rx_valid = (k == n) || (k == mn);
      rx_ping_id = (k == n) ? m_id : mid;
      if (k < res + 1) step;
    end
    if (late) begin
      rx_valid = 1'b1;
      rx_ping_id = m_id;
    end
    if (hit) begin
      m_lat = 32'(n);
      m_pong++;
    end else begin
      m_lost++;
    end
    m_id++;
    cmp_n++;
    if (latency !== m_lat) begin
      err_n++;
      $display("FAIL latency: got %0d want %0d", latency, m_lat);
    end
    cmp_n++;
    if (ping_id !== m_id) begin
      err_n++;
      $display("FAIL ping_id: got %0d want %0d", ping_id, m_id);
    end
    cmp_n++;
    if ({ping_count, pong_count, lost_count} !==
        {m_ping, m_pong, m_lost}) begin
      err_n++;
      $display("FAIL counts: got %0d/%0d/%0d want %0d/%0d/%0d",
               ping_count, pong_count, lost_count,
               m_ping, m_pong, m_lost);
    end
    last_t = t;
    last_r = b_cyc + res;
    if (enable) begin
      exp_trig = t + period;
      if (last_r + 2 > exp_trig) exp_trig = last_r + 2;
    end else begin
      exp_trig = -1;
    end
    step;
    rx_valid = 1'b0;
    cmp_n++;
    if ({latency_valid, lost, pong_count} !== {2'b00, m_pong}) begin
      err_n++;
      $display("FAIL after_resolve: got lv=%0b lost=%0b pong=%0d want 0 0 %0d",
               latency_valid, lost, pong_count, m_pong);
    end
    if (drop) begin
      cmp_n++;
      if (busy !== 1'b0) begin
        err_n++;
        $display("FAIL busy_after_drop: got %0b want 0", busy);
      end
      got = 3'b000;
      repeat (20) begin
        step;
        got = got | {trigger, busy, latency_valid | lost};
      end
      cmp_n++;
      if (got !== 3'b000) begin
        err_n++;
        $display("FAIL idle_after_drop: got %b want 000", got);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    enable = 1'b0;
    period = 32'd100;
    timeout = 32'd50;
    tx_begin = 1'b0;
    rx_valid = 1'b0;
    rx_ping_id = '0;
    step;
    step;
    cmp_n++;
    if ({trigger, latency_valid, lost, busy, ping_id, latency,
         ping_count, pong_count, lost_count} !== '0) begin
      err_n++;
      $display("FAIL reset_state: got trig=%0b lv=%0b lost=%0b busy=%0b id=%0d",
               trigger, latency_valid, lost, busy, ping_id);
    end
    rst = 1'b0;
    step;
    cmp_n++;
    if ({trigger, busy} !== 2'b00) begin
      err_n++;
      $display("FAIL idle_no_enable: got %b want 00", {trigger, busy});
    end
  endtask

  task automatic test_basic;
    period = 32'd100;
    timeout = 32'd50;
    enable = 1'b1;
    exp_trig = cyc + 1;
    run_ping(3, 20, 0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    timeout = 32'd10;
    run_ping(2, 0, 0, 16'd0, 1'b1, 1'b0);
  endtask

  task automatic test_mismatch;
    timeout = 32'd50;
    run_ping(2, 9, 5, 16'd7, 1'b0, 1'b0);
  endtask

  task automatic test_simultaneous;
    timeout = 32'd15;
    run_ping(1, 15, 0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic test_short_period;
    timeout = 32'd50;
    set_period(1);
    repeat (10) run_ping(1, 4, 0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic test_enable_drop;
    set_period(30);
    run_ping(2, 6, 0, 16'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid;
    longint t;
    logic [2:0] got;
    enable = 1'b1;
    exp_trig = cyc + 1;
    wait_trigger(t);
    step;
    rst = 1'b1;
    enable = 1'b0;
    step;
    rst = 1'b0;
    cmp_n++;
    if ({trigger, latency_valid, lost, busy, ping_id, latency,
         ping_count, pong_count, lost_count} !== '0) begin
      err_n++;
      $display("FAIL reset_mid: got trig=%0b busy=%0b cnt=%0d lat=%0d",
               trigger, busy, ping_count, latency);
    end
    m_id = 0;
    m_ping = 0;
    m_pong = 0;
    m_lost = 0;
    m_lat = 0;
    got = 3'b000;
    repeat (15) begin
      tx_begin = $urandom_range(0, 1) == 1;
      rx_valid = $urandom_range(0, 1) == 1;
      rx_ping_id = 16'd0;
      step;
      got = got | {trigger | busy, latency_valid, lost};
    end
    tx_begin = 1'b0;
    rx_valid = 1'b0;
    cmp_n++;
    if (got !== 3'b000) begin
      err_n++;
      $display("FAIL spurious_after_reset: got %b want 000", got);
    end
  endtask

  task automatic test_random;
    int n;
    period = $urandom_range(0, 60);
    enable = 1'b1;
    exp_trig = cyc + 1;
    repeat (25) begin
      timeout = $urandom_range(0, 30);
      n = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
      run_ping(int'($urandom_range(1, 5)), n,
               int'($urandom_range(0, 40)),
               m_id ^ 16'($urandom_range(1, 65535)),
               $urandom_range(0, 1) == 1, 1'b0);
      set_period($urandom_range(0, 60));
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_timeout;
    test_mismatch;
    test_simultaneous;
    test_short_period;
    test_enable_drop;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
